// File: rtl/fft_addr_ctrl.sv
// Address and control sequencer for an in-place radix-2 DIT FFT on a dual-port RAM:
// bit-reversed sample load, then log2(N) stages of read / wait / write-back butterflies.
module fft_addr_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int BF_LAT     = 1,
  localparam int STAGE_W   = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  singlewrite,
  output logic                  roW,
  output logic [ADDR_WIDTH-1:0] A_addr,
  output logic [ADDR_WIDTH-1:0] B_addr,
  output logic [ADDR_WIDTH-2:0] tw_addr,
  output logic [STAGE_W-1:0]    stage,
  output logic                  bfly_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int WAIT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_WIDTH-1:0] k;
  logic [STAGE_W-1:0]    s;
  logic [ADDR_WIDTH-2:0] j;
  logic [WAIT_W-1:0]     wcnt;

  logic [ADDR_WIDTH-1:0] rev_k;
  logic [ADDR_WIDTH-1:0] j_ext;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] pos;
  logic [ADDR_WIDTH-1:0] a_calc;
  logic [ADDR_WIDTH-1:0] b_calc;
  logic [ADDR_WIDTH-1:0] tw_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      s     <= '0;
      j     <= '0;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k <= '0;
          s <= '0;
          j <= '0;
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (sample_valid) begin
            k <= k + 1'b1;
            if (k == {ADDR_WIDTH{1'b1}}) state <= S_RD;
          end
        end
        S_RD: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WAIT_W'(BF_LAT - 1)) state <= S_WR;
          else wcnt <= wcnt + 1'b1;
        end
        S_WR: begin
          // s is left at its last value on completion so it never wraps.
          if (j == {(ADDR_WIDTH-1){1'b1}}) begin
            j <= '0;
            if (s == STAGE_W'(ADDR_WIDTH - 1)) begin
              state <= S_DONE;
            end else begin
              s     <= s + 1'b1;
              state <= S_RD;
            end
          end else begin
            j     <= j + 1'b1;
            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rev_k = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) rev_k[i] = k[ADDR_WIDTH-1-i];
  end

  // Butterfly pair: insert a zero at bit s of j to get A; B sets that bit.
  always_comb begin
    j_ext   = {1'b0, j};
    mask    = (ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1);
    pos     = j_ext & mask;
    a_calc  = (((j_ext >> s) << s) << 1) | pos;
    b_calc  = a_calc | (ADDR_WIDTH'(1) << s);
    tw_full = pos << (STAGE_W'(ADDR_WIDTH - 1) - s);
  end

  always_comb begin
    sample_ready = 1'b0;
    singlewrite  = 1'b0;
    roW          = 1'b0;
    A_addr       = '0;
    B_addr       = '0;
    tw_addr      = '0;
    stage        = '0;
    bfly_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_LOAD: begin
        sample_ready = 1'b1;
        busy         = 1'b1;
        A_addr       = rev_k;
        singlewrite  = sample_valid & ~rst;
      end
      S_RD, S_WAIT, S_WR: begin
        busy       = 1'b1;
        A_addr     = a_calc;
        B_addr     = b_calc;
        tw_addr    = tw_full[ADDR_WIDTH-2:0];
        stage      = s;
        bfly_valid = (state == S_WAIT) && (wcnt == '0);
        roW        = (state == S_WR) && !rst;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Randomized bench for fft_addr_ctrl: two instances (BF_LAT 1 and 3) compared cycle by
// cycle against an expected output trace built from block/offset butterfly enumeration.
module tb_fft_addr_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic sample_valid;

  logic       sr1, sw1, row1, bv1, busy1, done1;
  logic [4:0] a1, b1;
  logic [3:0] tw1;
  logic [2:0] st1;

  logic       sr3, sw3, row3, bv3, busy3, done3;
  logic [4:0] a3, b3;
  logic [3:0] tw3;
  logic [2:0] st3;

  int checkCount = 0;
  int passCount  = 0;
  int curCycle   = 0;

  logic [22:0] modelQ[$];
  logic [22:0] exp1q[$];
  logic [22:0] exp3q[$];
  logic        loadPat[$];

  logic [4:0] rdA[80];
  logic [4:0] rdB[80];
  logic [3:0] rdT[80];

  fft_addr_ctrl #(.ADDR_WIDTH(5), .BF_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_ready(sr1), .singlewrite(sw1), .roW(row1), .A_addr(a1), .B_addr(b1),
    .tw_addr(tw1), .stage(st1), .bfly_valid(bv1), .busy(busy1), .done(done1)
  );

  fft_addr_ctrl #(.ADDR_WIDTH(5), .BF_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_ready(sr3), .singlewrite(sw3), .roW(row3), .A_addr(a3), .B_addr(b3),
    .tw_addr(tw3), .stage(st3), .bfly_valid(bv3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] pack(input logic sr, input logic sw, input logic row,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [3:0] tw, input logic [2:0] st,
                                       input logic bv, input logic bs, input logic dn);
    return {sr, sw, row, a, b, tw, st, bv, bs, dn};
  endfunction

  logic [22:0] obs1;
  logic [22:0] obs3;
  assign obs1 = pack(sr1, sw1, row1, a1, b1, tw1, st1, bv1, busy1, done1);
  assign obs3 = pack(sr3, sw3, row3, a3, b3, tw3, st3, bv3, busy3, done3);

  function automatic logic [4:0] bitrev5(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++)
      if (((k >> i) & 1) != 0) r = r + (1 << (4 - i));
    return 5'(r);
  endfunction

  task automatic checkOutput(input string tag, input logic [22:0] got, input logic [22:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, curCycle, got, exp);
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic applyStimulus(input logic st, input logic v, input logic r);
    @(posedge clk);
    #1;
    start        = st;
    sample_valid = v;
    rst          = r;
    @(negedge clk);
  endtask

  // Expected trace from the start cycle through DONE, for the load pattern in loadPat.
  task automatic buildModel(input int lat);
    int k;
    int half;
    int a;
    modelQ = {};
    modelQ.push_back('0);
    k = 0;
    foreach (loadPat[i]) begin
      modelQ.push_back(pack(1'b1, loadPat[i], 1'b0, bitrev5(k), 5'd0, 4'd0, 3'd0,
                            1'b0, 1'b1, 1'b0));
      if (loadPat[i]) k++;
    end
    for (int s = 0; s < 5; s++) begin
      half = 1 << s;
      for (int blk = 0; blk < 32; blk += 2 * half) begin
        for (int p = 0; p < half; p++) begin
          a = blk + p;
          modelQ.push_back(pack(1'b0, 1'b0, 1'b0, 5'(a), 5'(a + half), 4'(p * (16 / half)),
                                3'(s), 1'b0, 1'b1, 1'b0));
          for (int w = 0; w < lat; w++)
            modelQ.push_back(pack(1'b0, 1'b0, 1'b0, 5'(a), 5'(a + half), 4'(p * (16 / half)),
                                  3'(s), (w == 0), 1'b1, 1'b0));
          modelQ.push_back(pack(1'b0, 1'b0, 1'b1, 5'(a), 5'(a + half), 4'(p * (16 / half)),
                                3'(s), 1'b0, 1'b1, 1'b0));
        end
      end
    end
    modelQ.push_back(pack(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1));
  endtask

  // mode 0: continuous samples, 1: every other cycle, 2: random gaps.
  task automatic runTransform(input int mode);
    int acc;
    int idx;
    int len1;
    int total;
    int wrCount;
    int cmp3;
    int doneAt1;
    int doneAt3;
    int rdIdx;
    logic v;
    logic st;
    loadPat = {};
    acc = 0;
    idx = 0;
    while (acc < 32) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((idx % 2) == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      loadPat.push_back(v);
      if (v) acc++;
      idx++;
    end
    buildModel(1);
    exp1q = modelQ;
    len1  = exp1q.size();
    buildModel(3);
    exp3q = modelQ;
    total = exp3q.size() + 2;
    while (exp1q.size() < total) exp1q.push_back('0);
    while (exp3q.size() < total) exp3q.push_back('0);

    wrCount = 0;
    cmp3    = 0;
    doneAt1 = -1;
    doneAt3 = -1;
    rdIdx   = 0;
    for (int c = 0; c < total; c++) begin
      curCycle = c;
      st = (c == 0) ? 1'b1 : ((c < len1) && ($urandom_range(0, 7) == 0));
      v  = (c >= 1 && c <= loadPat.size()) ? loadPat[c-1] : 1'($urandom_range(0, 1));
      applyStimulus(st, v, 1'b0);
      checkOutput("trace_lat1", obs1, exp1q[c]);
      checkOutput("trace_lat3", obs3, exp3q[c]);
      if (done1) doneAt1 = c;
      if (done3) doneAt3 = c;
      if (row1) wrCount++;
      if (busy3 && !sr3) cmp3++;
      if (busy1 && !sr1 && !row1 && !bv1) begin
        if (rdIdx < 80) begin
          rdA[rdIdx] = a1;
          rdB[rdIdx] = b1;
          rdT[rdIdx] = tw1;
        end
        rdIdx++;
      end
    end
    checkOutput("done_cycle_lat1", 23'(doneAt1), 23'(loadPat.size() + 241));
    checkOutput("done_cycle_lat3", 23'(doneAt3), 23'(loadPat.size() + 401));
    checkOutput("wr_count_lat1", 23'(wrCount), 23'(80));
    checkOutput("compute_cycles_lat3", 23'(cmp3), 23'(400));
    checkOutput("rd_count_lat1", 23'(rdIdx), 23'(80));
    checkOutput("rd_s0_j0", 23'({rdA[0], rdB[0], rdT[0]}), 23'({5'd0, 5'd1, 4'd0}));
    checkOutput("rd_s0_j1", 23'({rdA[1], rdB[1], rdT[1]}), 23'({5'd2, 5'd3, 4'd0}));
    checkOutput("rd_s0_j2", 23'({rdA[2], rdB[2], rdT[2]}), 23'({5'd4, 5'd5, 4'd0}));
    checkOutput("rd_s2_j5", 23'({rdA[37], rdB[37], rdT[37]}), 23'({5'd9, 5'd13, 4'd4}));
    checkOutput("rd_s4_j15", 23'({rdA[79], rdB[79], rdT[79]}), 23'({5'd15, 5'd31, 4'd15}));
  endtask

  // Reset in the WAIT cycle of a stage-2 butterfly, then watch for stray strobes.
  task automatic midReset();
    logic found;
    found = 1'b0;
    curCycle = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 2000 && !found; c++) begin
      curCycle = c;
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bv1 && st1 == 3'd2) found = 1'b1;
    end
    checkOutput("rst_target_found", 23'(found), 23'(1));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst_mid_lat1", obs1, 23'd0);
    checkOutput("rst_mid_lat3", obs3, 23'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("post_rst_lat1", obs1, 23'd0);
      checkOutput("post_rst_lat3", obs3, 23'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b1;
    sample_valid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_c0_lat1", obs1, 23'd0);
    checkOutput("reset_c0_lat3", obs3, 23'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_c1_lat1", obs1, 23'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_in_reset_ignored", obs1, 23'd0);

    runTransform(0);
    runTransform(1);
    runTransform(2);
    midReset();
    runTransform(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fft_addr_ctrl.md
# fft_addr_ctrl

Sequencing controller for the in-place radix-2 DIT FFT memory. It sits directly upstream of the dual-port FFT RAM and drives that RAM's `roW`, `singlewrite`, `A_addr` and `B_addr` inputs. It has three phases: load N input samples at bit-reversed addresses, run log2(N) butterfly stages as read / wait-for-butterfly / write-back, then pulse `done`. It supplies addresses and control only; sample data and butterfly results travel on the external datapath.

## Interface
- `ADDR_WIDTH`, default 5, gives log2(N); N = 32 points, STAGES = ADDR_WIDTH.
- `BF_LAT`, default 1, is the butterfly latency in cycles (≥1), measured from RAM output valid to result valid.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a transform; sampled only in IDLE.
- `sample_valid`  in  1  input sample is present on the RAM `data_in_A` this cycle.
- `sample_ready`  out  1  high throughout LOAD.
- `singlewrite`  out  1  drives the RAM `singlewrite` input.
- `roW`  out  1  drives the RAM `roW` input (1 = pair write).
- `A_addr`  out  ADDR_WIDTH  RAM port A address.
- `B_addr`  out  ADDR_WIDTH  RAM port B address.
- `tw_addr`  out  ADDR_WIDTH-1  twiddle ROM index for the current butterfly.
- `stage`  out  ceil(log2(ADDR_WIDTH))  current stage number, 0..STAGES-1.
- `bfly_valid`  out  1  RAM `data_out_A`/`data_out_B` hold the current pair this cycle.
- `busy`  out  1  high in LOAD, RD, WAIT and WR.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, LOAD, RD, WAIT, WR, DONE.
- **IDLE:**
  - `start` = 1 moves to LOAD.
  - Clears the sample counter k, the stage counter s and the butterfly counter j.
- **LOAD:**
  - `A_addr` = bitrev(k); `singlewrite` = `sample_valid`. This path is combinational from the input.
  - k increments on each cycle with `sample_valid` = 1.
  - Gaps in `sample_valid` hold k.
  - Accepting the sample at k = N-1 moves to RD.
- **Address math,** for stage s and butterfly j = 0..N/2-1:
  - pos = j & (2^s − 1)
  - A = ((j >> s) << (s+1)) | pos
  - B = A + 2^s
  - tw_addr = pos << (STAGES−1−s)
  - All results are unsigned and fit ADDR_WIDTH with no overflow.
- **RD:** present A/B with `roW` = 0, then move to WAIT.
- **WAIT:**
  - Lasts exactly BF_LAT cycles.
  - `bfly_valid` = 1 in the first WAIT cycle only.
  - A/B and `tw_addr` are held.
- **WR:**
  - Present the same A/B with `roW` = 1; the butterfly results are on `data_in_A`/`data_in_B`.
  - Then j increments. When j wraps from N/2−1 to 0, s increments.
  - After the WR with s = STAGES−1 and j = N/2−1, move to DONE; otherwise move to RD.
- **DONE:** `done` = 1 for one cycle, then move to IDLE.
- **Outputs outside their own state:**
  - `singlewrite` = 0 and `roW` = 0, except as defined above.
  - A_addr, B_addr, tw_addr and stage are 0 in IDLE and DONE.
  - B_addr is 0 in LOAD.
- **Boundaries:**
  - `start` outside IDLE is ignored; this includes DONE.
  - `sample_valid` outside LOAD is ignored.
  - `rst` wins over every other input.
  - `rst` mid-operation, in any state, returns to IDLE at the next edge. RAM contents are not touched, and no write strobe is asserted in the reset cycle's outcome.

## Timing
- **Reset values:** IDLE; all outputs 0, including `busy`, `done`, `sample_ready` and `bfly_valid`.
- **Start and load:**
  - `start` sampled at cycle 0 puts LOAD in cycle 1.
  - With continuous `sample_valid`, LOAD covers cycles 1..N.
- **Per butterfly:** 2 + BF_LAT cycles. The RAM read is registered, so data is valid the cycle after RD, which aligns with `bfly_valid`.
- **Compute phase:** (N/2)·STAGES·(2+BF_LAT) cycles, which is 240 for the defaults.
- **Total, defaults with no load gaps:** `done` is high in cycle 273 and IDLE returns in cycle 274.
- **Sequence for one butterfly:** RD in cycle t (`roW` = 0), `bfly_valid` in t+1, WR in t+1+BF_LAT (`roW` = 1), next RD in t+2+BF_LAT.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> all outputs 0; `start` held during `rst` is ignored.
- **Load order:** start, then 32 continuous samples -> `singlewrite` high for 32 cycles with `A_addr` = 0, 16, 8, 24, 4, …, 31; RD follows in the next cycle.
- **Load gaps:** drop `sample_valid` on every other cycle -> no write in gap cycles, k holds, and the address sequence is unchanged.
- **Addresses:**
  - Stage 0, j = 0..2 -> (A,B,tw) = (0,1,0), (2,3,0), (4,5,0).
  - Stage 4, j = 15 -> (15,31,15).
  - Stage 2, j = 5 -> (9,13,4).
  - `bfly_valid` is one cycle after each RD.
- **Completion:** BF_LAT = 1, continuous load -> exactly 80 WR cycles, `done` in cycle 273; repeat with BF_LAT = 3 -> 400 compute cycles.
- **Reset mid-operation:** `rst` during a WAIT in stage 2 -> IDLE next cycle with no further `roW`/`singlewrite`; `start` mid-compute is ignored; a fresh `start` afterwards runs a full correct transform.
